// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if
// Bundles the request/data side and the grant/muxed-lane side of the
// 8:1 round-robin arbiter into one interface.
//   req        : per-lane request, bit n requests lane n
//   din        : packed lane data, lane n at din[n*W +: W]
//   sel        : binary index of the current grant holder
//   gnt        : one-hot grant, zero when idle
//   dout       : registered data of the selected lane
//   dout_valid : dout holds a valid granted sample
//   busy       : arbiter is in its GRANT state
//   lock       : (only with MUX8_ARB_LOCK_EN) extends a burst past MAX_BURST
// Modports: master = requesters/consumer side, slave = arbiter side.
interface mux8_rr_arbiter_if #(
  parameter int W = 1
);
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic [2:0]     sel;
  logic [7:0]     gnt;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           busy;
`ifdef MUX8_ARB_LOCK_EN
  logic           lock;

  modport master (
    output req, din, lock,
    input  sel, gnt, dout, dout_valid, busy
  );

  modport slave (
    input  req, din, lock,
    output sel, gnt, dout, dout_valid, busy
  );
`else
  modport master (
    output req, din,
    input  sel, gnt, dout, dout_valid, busy
  );

  modport slave (
    input  req, din,
    output sel, gnt, dout, dout_valid, busy
  );
`endif
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
// Round-robin arbiter and select sequencer for an 8:1 mux datapath. One
// requester at a time owns the output lane; each grant is bounded to
// MAX_BURST consecutive cycles, after which the search restarts just past
// the previous holder so every requester gets a turn. The selected lane is
// registered to dout one cycle after the grant becomes visible.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : mux8_rr_arbiter_if.slave (req, din, [lock] in; sel, gnt, dout,
//         dout_valid, busy out)
// Parameters:
//   W         : data width per lane
//   MAX_BURST : maximum consecutive grant cycles per holder (1..255)
// Optional feature macro: MUX8_ARB_LOCK_EN adds a lock input that lets the
// current holder keep the grant past MAX_BURST while it keeps requesting.
module mux8_rr_arbiter #(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  mux8_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  state_t       state_q;
  logic [2:0]   ptr_q;
  logic [2:0]   sel_q;
  logic [7:0]   gnt_q;
  logic [7:0]   cnt_q;
  logic [W-1:0] dout_q;
  logic         dout_valid_q;
  logic         busy_q;

  logic [W-1:0] lane [8];
  logic [7:0]   rot_req;
  logic [2:0]   search_base;
  logic [2:0]   pick_ofs;
  logic [2:0]   pick;
  logic         any_req;
  logic         req_hold;
  logic         at_limit;
  logic         hold;

  // In GRANT the search only matters on release, and then it must start
  // just past the holder, so the next pointer value is used directly
  // instead of waiting a cycle for ptr_q to update.
  assign search_base = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;
  assign any_req     = |bus.req;
  assign req_hold    = bus.req[sel_q];
  assign at_limit    = (cnt_q >= MAX_CNT);

`ifdef MUX8_ARB_LOCK_EN
  assign hold = req_hold && (!at_limit || bus.lock);
`else
  assign hold = req_hold && !at_limit;
`endif

  // Rotate the request vector so bit 0 corresponds to the search start;
  // the pick is then a plain lowest-set-bit search.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane[gi]    = bus.din[gi*W +: W];
      assign rot_req[gi] = bus.req[search_base + 3'(gi)];
    end
  endgenerate

  always_comb begin
    pick_ofs = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick_ofs = 3'(i);
      end
    end
  end

  assign pick = search_base + pick_ofs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 3'd0;
      sel_q        <= 3'd0;
      gnt_q        <= 8'd0;
      cnt_q        <= 8'd0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Sample uses the select in effect before this edge.
      dout_valid_q <= (state_q == GRANT) && req_hold;
      if ((state_q == GRANT) && req_hold) begin
        dout_q <= lane[sel_q];
      end

      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= GRANT;
            busy_q  <= 1'b1;
            sel_q   <= pick;
            gnt_q   <= 8'd1 << pick;
            cnt_q   <= 8'd1;
          end
        end

        GRANT: begin
          if (hold) begin
            // Saturates at the limit when lock extends the burst.
            if (!at_limit) begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else begin
            ptr_q <= sel_q + 3'd1;
            if (any_req) begin
              // A lone requester at its limit wraps back to itself here.
              sel_q <= pick;
              gnt_q <= 8'd1 << pick;
              cnt_q <= 8'd1;
            end else begin
              // sel keeps the last holder's index while idle.
              state_q <= IDLE;
              busy_q  <= 1'b0;
              gnt_q   <= 8'd0;
              cnt_q   <= 8'd0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          gnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;

endmodule
